// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: parametrised inter-stage pipeline register.
// It holds a PC, an instruction word and NUM_OPS operands in a main/skid pair
// with a valid/ready handshake, synchronous flush and bubble (NOP) insertion.
// The performance counters are built only when PIPE_STAGE_PERF_EN is defined.
// When it is not defined, the counter ports still exist and are tied to zero.
module pipe_stage_latch #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSN_W   = 32,
  parameter int unsigned     DATA_W   = 32,
  parameter int unsigned     NUM_OPS  = 2,
  parameter logic [INSN_W-1:0] NOP_INSN = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_W-1:0]           in_pc,
  input  logic [INSN_W-1:0]         in_insn,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_W-1:0]           out_pc,
  output logic [INSN_W-1:0]         out_insn,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  input  logic                      flush,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam int unsigned OPS_W = NUM_OPS * DATA_W;

  if (NUM_OPS < 1 || NUM_OPS > 4) begin : g_bad_num_ops
    $error("pipe_stage_latch: NUM_OPS must be in 1..4");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic load_m_in;
  logic load_m_skid;
  logic load_s_in;
  logic accept;
  logic consume;

  logic [PC_W-1:0]   m_pc,   s_pc;
  logic [INSN_W-1:0] m_insn, s_insn;
  logic [OPS_W-1:0]  m_ops,  s_ops;

  // Both handshake outputs decode directly from the state flops, so neither
  // one has a combinational path from out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // State register; reset discards both entries regardless of flush/handshake
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next-state and entry load controls; flush forces EMPTY over any handshake
  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s_in   = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_m_in = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (consume && accept) begin
            load_m_in = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            load_s_in = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (consume) begin
            load_m_skid = 1'b1;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Entry field registers; validity lives in the state, so no reset is needed
  always_ff @(posedge clock) begin
    if (load_m_in) begin
      m_pc   <= in_pc;
      m_insn <= in_insn;
      m_ops  <= in_ops;
    end else if (load_m_skid) begin
      m_pc   <= s_pc;
      m_insn <= s_insn;
      m_ops  <= s_ops;
    end
    if (load_s_in) begin
      s_pc   <= in_pc;
      s_insn <= in_insn;
      s_ops  <= in_ops;
    end
  end

  // The output mux makes a bubble look like a NOP. Stale field contents are never visible.
  assign out_pc   = out_valid ? m_pc   : '0;
  assign out_insn = out_valid ? m_insn : NOP_INSN;
  assign out_ops  = out_valid ? m_ops  : '0;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

  // Saturating event counters sampled from the pre-edge state (flush cycles included)
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (out_valid && !out_ready && stall_q != '1)  stall_q  <= stall_q + CNT_W'(1);
      if (!out_valid && out_ready && bubble_q != '1) bubble_q <= bubble_q + CNT_W'(1);
      if (flush && flush_q != '1)                    flush_q  <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb_pipe_stage_latch: scoreboard bench for pipe_stage_latch.
// A reference model pushes expected packets on accept. A negedge monitor
// compares the outputs, handshake and counters against the model.
// The bench also checks the consumed PC sequences against hand-written lists.
module tb_pipe_stage_latch;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSN_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_OPS = 2;
  localparam int unsigned CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          CMAX    = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, flush;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [INSN_W-1:0] in_insn, out_insn;
  logic [NUM_OPS*DATA_W-1:0] in_ops, out_ops;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

  pipe_stage_latch #(
    .PC_W(PC_W), .INSN_W(INSN_W), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS),
    .NOP_INSN(NOP), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_insn(in_insn), .in_ops(in_ops),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_insn(out_insn), .out_ops(out_ops),
    .flush(flush),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [63:0] ops;
  } pkt_t;

  pkt_t        model_q[$];
  logic [31:0] seen[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int          m_stall = 0, m_bubble = 0, m_flush = 0;
  bit          mon_en = 1'b0;

  function automatic pkt_t mk(input logic [31:0] pc);
    pkt_t p;
    p.pc   = pc;
    p.insn = 32'hC000_0000 ^ (pc << 4);
    p.ops  = {pc + 32'h200, pc + 32'h100};
    return p;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: advances on each edge using only stimulus and its own state
  always @(posedge clock) begin
    bit ov, cons, acc;
    if (reset) begin
      model_q.delete();
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end else begin
      ov = (model_q.size() > 0);
      if (PERF) begin
        if (ov && !out_ready && m_stall < CMAX)  m_stall++;
        if (!ov && out_ready && m_bubble < CMAX) m_bubble++;
        if (flush && m_flush < CMAX)             m_flush++;
      end
      if (flush) begin
        model_q.delete();
      end else begin
        cons = ov && out_ready;
        acc  = in_valid && (model_q.size() < 2);
        if (cons) void'(model_q.pop_front());
        if (acc)  model_q.push_back(pkt_t'{in_pc, in_insn, in_ops});
      end
    end
  end

  // Monitor: compares the DUT against the model head and records consumed PCs
  always @(negedge clock) begin
    pkt_t e;
    if (mon_en) begin
      chk("out_valid", out_valid, model_q.size() > 0);
      chk("in_ready", in_ready, model_q.size() < 2);
      if (model_q.size() > 0) begin
        e = model_q[0];
        chk("out_pc", out_pc, e.pc);
        chk("out_insn", out_insn, e.insn);
        chk("out_ops", out_ops, e.ops);
      end else begin
        chk("bubble_pc", out_pc, 0);
        chk("bubble_insn", out_insn, NOP);
        chk("bubble_ops", out_ops, 0);
      end
      chk("stall_cnt", stall_cnt, m_stall);
      chk("bubble_cnt", bubble_cnt, m_bubble);
      chk("flush_cnt", flush_cnt, m_flush);
      if (out_valid && out_ready && !flush && !reset) seen.push_back(out_pc);
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic ordy,
                      input logic fl, input logic rst);
    pkt_t p;
    p = mk(pc);
    in_valid = v; in_pc = p.pc; in_insn = p.insn; in_ops = p.ops;
    out_ready = ordy; flush = fl; reset = rst;
    @(posedge clock);
    #1;
  endtask

  task automatic check_seen(input string nm, input int n,
                            input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] ex[3];
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    chk({nm, "_count"}, seen.size(), n);
    for (int i = 0; i < n && i < seen.size(); i++) chk({nm, "_order"}, seen[i], ex[i]);
    seen.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_insn = '0; in_ops = '0;
    step(0, 0, 0, 0, 1);
    mon_en = 1'b1;
    step(0, 0, 0, 0, 1);
    @(negedge clock);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_insn", out_insn, NOP);
    #1;

    // Streaming at full rate
    seen.delete();
    step(1, 32'h10, 1, 0, 0);
    @(negedge clock); chk("stream_first_pc", out_pc, 32'h10); #1;
    step(1, 32'h11, 1, 0, 0);
    step(1, 32'h12, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_seen("stream", 3, 32'h10, 32'h11, 32'h12);

    // Backpressure into FULL, an ignored offer while full, then drain
    step(1, 32'h20, 0, 0, 0);
    step(1, 32'h21, 0, 0, 0);
    @(negedge clock); chk("full_in_ready", in_ready, 0); #1;
    step(1, 32'h22, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    @(negedge clock); chk("drain_in_ready", in_ready, 1); #1;
    check_seen("backpressure", 2, 32'h20, 32'h21, 0);

    // Flush while FULL with a new offer present
    step(1, 32'h28, 0, 0, 0);
    step(1, 32'h29, 0, 0, 0);
    step(1, 32'h30, 0, 1, 0);
    @(negedge clock);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_insn", out_insn, NOP);
    chk("flush_in_ready", in_ready, 1);
    #1;
    // Flush in ONE while a packet is handshaken: that packet is dropped
    step(1, 32'h31, 0, 0, 0);
    step(1, 32'h32, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_seen("flush", 0, 0, 0, 0);

    // Idle bubble
    step(0, 32'h77, 0, 0, 0);
    @(negedge clock);
    chk("idle_insn", out_insn, NOP);
    chk("idle_pc", out_pc, 0);
    chk("idle_ops", out_ops, 0);
    #1;

    // Counters from a fresh reset: 5 stalls, 3 bubbles, 2 flushes
    step(0, 0, 0, 0, 1);
    step(1, 32'h40, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);
    @(negedge clock);
    chk("cnt_stall", stall_cnt, PERF ? 5 : 0);
    chk("cnt_bubble", bubble_cnt, PERF ? 3 : 0);
    chk("cnt_flush", flush_cnt, PERF ? 2 : 0);
    #1;
    step(1, 32'h41, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    @(negedge clock); chk("cnt_stall_sat", stall_cnt, PERF ? 15 : 0); #1;
    check_seen("counters", 1, 32'h40, 0, 0);

    // Reset with flush in FULL
    step(0, 0, 1, 1, 0);
    step(1, 32'h50, 0, 0, 0);
    step(1, 32'h51, 0, 0, 0);
    step(1, 32'h52, 1, 1, 1);
    @(negedge clock);
    chk("rst_full_valid", out_valid, 0);
    chk("rst_full_ready", in_ready, 1);
    chk("rst_full_insn", out_insn, NOP);
    chk("rst_full_pc", out_pc, 0);
    chk("rst_full_cnts", {stall_cnt, bubble_cnt, flush_cnt}, 0);
    #1;
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_seen("reset_full", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_latch.md
# pipe_stage_latch

Parametrised inter-stage pipeline register replacing the fixed fetch/decode, decode/execute, execute/memory and memory/writeback latches. It carries a PC, an instruction word and NUM_OPS data operands between adjacent stages. It adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, synchronous flush with NOP bubble insertion, and optional performance counters. One instance sits between each pair of pipeline stages.

## Interface
- PC_W, 32, PC field width
- INSN_W, 32, instruction field width
- DATA_W, 32, width of each operand
- NUM_OPS, 2, operand count (1..4); 0 is illegal
- NOP_INSN, 0, instruction value driven when out_valid=0
- CNT_W, 32, performance counter width
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream stage has a packet
- in_ready  out  1  latch can accept; registered, equals skid-entry empty
- in_pc  in  PC_W  upstream PC (e.g. pc+1)
- in_insn  in  INSN_W  upstream instruction
- in_ops  in  NUM_OPS*DATA_W  operands; op k at [k*DATA_W +: DATA_W]
- out_valid  out  1  packet present at output
- out_ready  in  1  downstream consumes this cycle
- out_pc, out_insn, out_ops  out  as inputs  main-entry fields
- flush  in  1  kill all held packets (branch mispredict/exception)
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Two entries: main M (drives outputs) and skid S. Each entry has a valid bit and the full field set.
- States: EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1). S valid with M invalid is unreachable.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- EMPTY: accept -> M loads, go ONE.
- ONE, consume & accept -> M reloads (ONE). Consume only -> EMPTY. Accept only -> S loads, FULL. Neither -> hold.
- FULL: in_ready=0. Consume -> M takes S, S cleared, ONE. No consume -> hold.
- flush: next state EMPTY regardless of accept or consume in the same cycle. A packet handshaken in the flush cycle is dropped. Flush has priority over everything except reset.
- Bubble rule: when out_valid=0, out_insn=NOP_INSN, out_pc=0 and out_ops=0. Field registers are not required to clear; output muxing is allowed.
- Packets never reorder or duplicate. in_* fields are sampled only on accept.

## Timing
- Reset: out_valid=0, in_ready=1, out_insn=NOP_INSN, out_pc=0, out_ops=0, all counters 0. Reset overrides flush and handshakes. Asserting reset mid-FULL discards both entries.
- Latency: 1 cycle. A packet accepted at edge n is visible at out_* after edge n.
- Throughput: 1 packet/cycle with out_ready held high.
- in_ready is registered and does not depend combinationally on out_ready. out_valid and out_* are registered.
- in_ready deasserts only in FULL. It reasserts the cycle after a consume or flush.
- in_ready=1 in the cycle after flush.

## Configuration
- PIPE_STAGE_PERF_EN defined: counters run.
  - stall_cnt increments when out_valid & !out_ready.
  - bubble_cnt increments when !out_valid & out_ready.
  - flush_cnt increments per flush cycle.
  - Counters saturate at 2^CNT_W-1 and clear only on reset.
  - A flush cycle updates stall_cnt/bubble_cnt from pre-flush state.
- Not defined: counter ports remain present, tied to 0. No counter flops are synthesised.

## Test plan
- Reset then stream: in_valid=1 and out_ready=1 held, in_pc=0x10,0x11,0x12 -> out_pc 0x10,0x11,0x12 on consecutive cycles starting 1 cycle later; in_ready stays 1.
- Backpressure: out_ready=0 while pushing A=0x20, B=0x21 -> FULL, in_ready=0 after B. Then out_ready=1 -> outputs A then B, no loss or duplicate, in_ready returns to 1.
- Flush in FULL with simultaneous in_valid=1 (pc 0x30) -> next cycle out_valid=0, out_insn=NOP_INSN, in_ready=1; 0x30 never appears at output.
- Bubble: idle with NOP_INSN=32'h13 -> out_insn=0x13, out_pc=0, out_ops=0.
- Reset asserted in FULL while flush=1 -> all outputs at reset values next cycle; counters 0.
- With PIPE_STAGE_PERF_EN: 5 stall cycles, 3 idle cycles with out_ready=1, 2 flushes -> stall_cnt=5, bubble_cnt=3, flush_cnt=2. With CNT_W=4, hold stall 20 cycles -> stall_cnt=15. Without macro -> all counters read 0.
